// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine controller.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vm_state_t;

  localparam logic [1:0] COIN_IDX0 = 2'd0;
  localparam logic [1:0] COIN_IDX1 = 2'd1;
  localparam logic [1:0] COIN_IDX2 = 2'd2;
  localparam logic [1:0] COIN_IDX3 = 2'd3;

  localparam int COIN_VAL0 = 1;
  localparam int COIN_VAL1 = 5;
  localparam int COIN_VAL2 = 10;
  localparam int COIN_VAL3 = 25;

endpackage

// File: rtl/vm_coin_decode.sv
// Maps a coin denomination index to its credit value.
module vm_coin_decode
  import vm_pkg::*;
#(
  parameter int W     = 8,
  parameter int COIN0 = COIN_VAL0,
  parameter int COIN1 = COIN_VAL1,
  parameter int COIN2 = COIN_VAL2,
  parameter int COIN3 = COIN_VAL3
) (
  input  logic [1:0]   coin_sel,
  output logic [W-1:0] value
);

  always_comb begin
    value = '0;
    unique case (coin_sel)
      COIN_IDX0: value = W'(COIN0);
      COIN_IDX1: value = W'(COIN1);
      COIN_IDX2: value = W'(COIN2);
      COIN_IDX3: value = W'(COIN3);
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/vm_change.sv
// Vending controller: multi-coin credit, one-cycle vend, unit-by-unit change via hopper.
module vm_change
  import vm_pkg::*;
#(
  parameter int PRICE = 15,
  parameter int W     = 8,
  parameter int COIN0 = COIN_VAL0,
  parameter int COIN1 = COIN_VAL1,
  parameter int COIN2 = COIN_VAL2,
  parameter int COIN3 = COIN_VAL3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         coin_valid,
  input  logic [1:0]   coin_sel,
  input  logic         cancel,
  input  logic         hopper_ready,
  output logic         dispense,
  output logic         change_pulse,
  output logic         coin_reject,
  output logic [W-1:0] credit,
  output logic         busy
);

  localparam logic [W-1:0] PRICE_W  = W'(PRICE);
  localparam logic [W:0]   PRICE_W1 = (W+1)'(PRICE);

  vm_state_t    state;
  logic [W-1:0] value;
  logic [W:0]   sum;
  logic [W-1:0] remainder;
  logic         accept;

  vm_coin_decode #(
    .W(W), .COIN0(COIN0), .COIN1(COIN1), .COIN2(COIN2), .COIN3(COIN3)
  ) u_decode (
    .coin_sel (coin_sel),
    .value    (value)
  );

  assign sum       = {1'b0, credit} + {1'b0, value};
  assign remainder = credit - PRICE_W;
  assign accept    = coin_valid && !cancel && !sum[W] &&
                     (state == IDLE || state == COLLECT);

  // Any presented coin that is not accepted is refused; gated so reset holds outputs low.
  assign coin_reject  = reset && coin_valid && !accept;
  assign change_pulse = reset && (state == CHANGE) && hopper_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      credit   <= '0;
      dispense <= 1'b0;
      busy     <= 1'b0;
    end else begin
      dispense <= 1'b0;
      unique case (state)
        IDLE, COLLECT: begin
          if (accept) begin
            credit <= sum[W-1:0];
            if (sum >= PRICE_W1) begin
              state    <= VEND;
              dispense <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end else if (state == COLLECT && cancel) begin
            // A zero credit (only possible with a zero-valued coin) has nothing to refund.
            if (credit != '0) begin
              state <= CHANGE;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        VEND: begin
          credit <= remainder;
          if (remainder != '0) begin
            state <= CHANGE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CHANGE: begin
          if (hopper_ready) begin
            credit <= credit - W'(1);
            if (credit == W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change.sv
// Directed bench for vm_change: default config plus a narrow W=5 instance for overflow.
module tb_vm_change;

  logic       clock;
  logic       reset;
  logic       coin_valid, cancel, hopper_ready;
  logic [1:0] coin_sel;
  logic       dispense, change_pulse, coin_reject, busy;
  logic [7:0] credit;

  logic       b_coin_valid, b_cancel, b_hopper_ready;
  logic [1:0] b_coin_sel;
  logic       b_dispense, b_change_pulse, b_coin_reject, b_busy;
  logic [4:0] b_credit;

  int ntests = 0;
  int nfail  = 0;

  vm_change #(.PRICE(15), .W(8)) dut (
    .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .cancel(cancel), .hopper_ready(hopper_ready), .dispense(dispense),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  vm_change #(.PRICE(30), .W(5)) dut_b (
    .clock(clock), .reset(reset), .coin_valid(b_coin_valid), .coin_sel(b_coin_sel),
    .cancel(b_cancel), .hopper_ready(b_hopper_ready), .dispense(b_dispense),
    .change_pulse(b_change_pulse), .coin_reject(b_coin_reject), .credit(b_credit), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks run 1ns later, well before the rising edge.
  task automatic drive(input logic cv, input logic [1:0] sel, input logic cn, input logic hr);
    @(negedge clock);
    coin_valid = cv; coin_sel = sel; cancel = cn; hopper_ready = hr;
    #1;
  endtask

  initial begin
    int exp_credit;
    int pulses;

    reset = 1'b0;
    coin_valid = 1'b1; coin_sel = 2'd3; cancel = 1'b1; hopper_ready = 1'b1;
    b_coin_valid = 1'b0; b_coin_sel = 2'd0; b_cancel = 1'b0; b_hopper_ready = 1'b0;
    #2;
    chk("rst_credit", credit, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_pulse", change_pulse, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Idle after reset
    drive(0, 0, 0, 0);
    chk("idle_credit", credit, 0);
    chk("idle_busy", busy, 0);
    chk("idle_dispense", dispense, 0);
    chk("idle_reject", coin_reject, 0);
    chk("idle_pulse", change_pulse, 0);

    // 5 + 10 = exact price
    drive(1, 1, 0, 0);
    chk("t2_reject5", coin_reject, 0);
    drive(1, 2, 0, 0);
    chk("t2_credit5", credit, 5);
    chk("t2_nodisp", dispense, 0);
    chk("t2_reject10", coin_reject, 0);
    drive(0, 0, 0, 0);
    chk("t2_credit15", credit, 15);
    chk("t2_disp", dispense, 1);
    chk("t2_busy", busy, 1);
    drive(0, 0, 0, 1);
    chk("t2_credit0", credit, 0);
    chk("t2_disp_once", dispense, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_nopulse", change_pulse, 0);

    // 25 with hopper always ready: 10 back-to-back pulses
    drive(1, 3, 0, 1);
    drive(0, 0, 0, 1);
    chk("t3_disp", dispense, 1);
    chk("t3_vend_credit", credit, 25);
    chk("t3_vend_nopulse", change_pulse, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1);
      chk("t3_pulse", change_pulse, 1);
      chk("t3_credit", credit, 10 - i);
      chk("t3_busy", busy, 1);
      chk("t3_nodisp", dispense, 0);
    end
    drive(0, 0, 0, 1);
    chk("t3_done_pulse", change_pulse, 0);
    chk("t3_done_credit", credit, 0);
    chk("t3_done_busy", busy, 0);

    // 25 with hopper toggling: 10 pulses over 20 cycles
    drive(1, 3, 0, 0);
    drive(0, 0, 0, 0);
    chk("t3b_disp", dispense, 1);
    exp_credit = 10;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, logic'(i % 2));
      chk("t3b_pulse", change_pulse, i % 2);
      chk("t3b_credit", credit, exp_credit);
      if (i % 2 == 1) begin
        exp_credit--;
        pulses++;
      end
    end
    drive(0, 0, 0, 1);
    chk("t3b_count", pulses, 10);
    chk("t3b_done_credit", credit, 0);
    chk("t3b_done_pulse", change_pulse, 0);
    chk("t3b_done_busy", busy, 0);

    // 5 then cancel with a simultaneous 10: cancel wins, refund 5
    drive(1, 1, 0, 1);
    drive(1, 2, 1, 1);
    chk("t4_reject", coin_reject, 1);
    chk("t4_credit", credit, 5);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1);
      chk("t4_pulse", change_pulse, 1);
      chk("t4_credit_dec", credit, 5 - i);
      chk("t4_nodisp", dispense, 0);
    end
    drive(0, 0, 0, 1);
    chk("t4_done_credit", credit, 0);
    chk("t4_done_busy", busy, 0);

    // Coin during CHANGE is refused and does not disturb the refund
    drive(1, 3, 0, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(i == 1, 0, 0, 1);
      chk("t5_credit", credit, 10 - i);
      chk("t5_pulse", change_pulse, 1);
      chk("t5_reject", coin_reject, i == 1);
    end
    drive(0, 0, 0, 1);
    chk("t5_done_credit", credit, 0);

    // Overflow on the W=5, PRICE=30 instance
    @(negedge clock);
    b_coin_valid = 1'b1; b_coin_sel = 2'd3;
    #1;
    chk("ovf_first_reject", b_coin_reject, 0);
    @(negedge clock);
    b_coin_sel = 2'd2;
    #1;
    chk("ovf_credit25", b_credit, 25);
    chk("ovf_reject", b_coin_reject, 1);
    @(negedge clock);
    b_coin_valid = 1'b0;
    #1;
    chk("ovf_hold", b_credit, 25);
    chk("ovf_nodisp", b_dispense, 0);
    chk("ovf_busy", b_busy, 0);

    // Async reset in the middle of CHANGE
    drive(1, 3, 0, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      chk("t6_credit", credit, 10 - i);
    end
    @(posedge clock);
    #2;
    chk("t6_pre_credit", credit, 7);
    reset = 1'b0;
    #1;
    chk("t6_rst_credit", credit, 0);
    chk("t6_rst_pulse", change_pulse, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_b_credit", b_credit, 0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 0, 1);
    chk("t6_after_credit", credit, 0);
    chk("t6_after_pulse", change_pulse, 0);
    chk("t6_after_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
